axi4_wr_aux_pipelined: RTL and testbench



---
 rtl/axi4_wr_aux_pipelined.sv | 212 +++++++++++++++++++++
 tb/tb_axi4_wr_aux_pipelined.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_aux_pipelined.sv
// Pipelined AXI4 write-address / W-burst framing controller with a burst-length queue.
// Optional AXI4_WR_RESP_TRACK_EN adds B-channel tracking, an outstanding-burst limit and sticky slverr.
module axi4_wr_aux_pipelined #(
  parameter int unsigned IDSIZE  = 4,
  parameter int unsigned ASIZE   = 32,
  parameter int unsigned LSIZE   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic [IDSIZE+ASIZE+LSIZE-1:0]   cmd_tdata,
  input  logic                            cmd_tvalid,
  output logic                            cmd_tready,
  output logic [IDSIZE-1:0]               axi_awid,
  output logic [ASIZE-1:0]                axi_awaddr,
  output logic [LSIZE-1:0]                axi_awlen,
  output logic                            axi_awvalid,
  input  logic                            axi_awready,
  input  logic                            in_wvalid,
  output logic                            in_wready,
  output logic                            axi_wvalid,
  input  logic                            axi_wready,
  output logic                            axi_wlast,
  output logic                            stream_en,
`ifdef AXI4_WR_RESP_TRACK_EN
  input  logic                            axi_bvalid,
  input  logic [1:0]                      axi_bresp,
  output logic                            axi_bready,
  output logic                            slverr,
  output logic [$clog2(MAX_OUT+1)-1:0]    outstanding,
`endif
  output logic                            dbg_w_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_OUT < 1) begin : g_bad_param
    $error("axi4_wr_aux_pipelined: DEPTH must be a power of 2 >= 2 and MAX_OUT >= 1");
  end

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // valid never depends on ready, and a held valid keeps its payload stable.
  typedef enum logic {W_IDLE = 1'b0, W_BURST = 1'b1} w_state_t;

  logic [IDSIZE-1:0] w_cmd_id;
  logic [ASIZE-1:0]  w_cmd_addr;
  logic [LSIZE-1:0]  w_cmd_len;
  logic              w_cmd_fire;
  logic              w_aw_fire;
  logic              w_aw_free;
  logic              w_out_room;

  logic [IDSIZE-1:0] r_awid;
  logic [ASIZE-1:0]  r_awaddr;
  logic [LSIZE-1:0]  r_awlen;
  logic              r_awvalid;

  logic [LSIZE-1:0]  r_q_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_qcnt;
  logic              w_q_empty;
  logic              w_q_full;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;

  w_state_t          r_state;
  w_state_t          w_state_nxt;
  logic [LSIZE-1:0]  r_cur_len;
  logic [LSIZE-1:0]  w_len_nxt;
  logic [LSIZE-1:0]  r_beat_cnt;
  logic [LSIZE-1:0]  w_beat_nxt;
  logic              w_last_beat;
  logic              w_w_fire;
  logic              w_take;

  assign w_cmd_len  = cmd_tdata[LSIZE-1:0];
  assign w_cmd_addr = cmd_tdata[LSIZE +: ASIZE];
  assign w_cmd_id   = cmd_tdata[LSIZE+ASIZE +: IDSIZE];

  assign w_aw_fire  = r_awvalid & axi_awready;
  assign w_aw_free  = !r_awvalid | axi_awready;
  assign w_q_empty  = (r_qcnt == '0);
  assign w_q_full   = (r_qcnt == CW'(DEPTH));
  assign cmd_tready = !rst & w_aw_free & !w_q_full & w_out_room;
  assign w_cmd_fire = cmd_tvalid & cmd_tready;

  assign axi_awid    = r_awid;
  assign axi_awaddr  = r_awaddr;
  assign axi_awlen   = r_awlen;
  assign axi_awvalid = r_awvalid;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_awvalid <= 1'b0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
    end else if (w_cmd_fire) begin
      r_awvalid <= 1'b1;
      r_awid    <= w_cmd_id;
      r_awaddr  <= w_cmd_addr;
      r_awlen   <= w_cmd_len;
    end else if (w_aw_fire) begin
      r_awvalid <= 1'b0;
    end
  end

  // A burst boundary (idle, or last beat firing) takes the next length; when the
  // queue is empty a same-cycle command length is taken directly so W starts at N+1.
  assign stream_en   = (r_state == W_BURST);
  assign axi_wvalid  = stream_en & in_wvalid;
  assign in_wready   = stream_en & axi_wready;
  assign w_last_beat = (r_beat_cnt == r_cur_len);
  assign axi_wlast   = stream_en & w_last_beat;
  assign w_w_fire    = axi_wvalid & axi_wready;
  assign w_take      = (r_state == W_IDLE) | (w_w_fire & w_last_beat);
  assign w_pop       = w_take & !w_q_empty;
  assign w_bypass    = w_take & w_q_empty & w_cmd_fire;
  assign w_push      = w_cmd_fire & !w_bypass;
  assign dbg_w_state = r_state;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_mem[r_wptr] <= w_cmd_len;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_qcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_qcnt <= r_qcnt + CW'(1);
        2'b01:   r_qcnt <= r_qcnt - CW'(1);
        default: r_qcnt <= r_qcnt;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_cur_len;
    w_beat_nxt  = r_beat_cnt;
    if (w_take) begin
      w_beat_nxt = '0;
      if (w_pop) begin
        w_state_nxt = W_BURST;
        w_len_nxt   = r_q_mem[r_rptr];
      end else if (w_bypass) begin
        w_state_nxt = W_BURST;
        w_len_nxt   = w_cmd_len;
      end else begin
        w_state_nxt = W_IDLE;
      end
    end else if (w_w_fire) begin
      w_beat_nxt = r_beat_cnt + LSIZE'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= W_IDLE;
      r_cur_len  <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_len  <= w_len_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

`ifdef AXI4_WR_RESP_TRACK_EN
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [OW-1:0] r_outstanding;
  logic          r_slverr;
  logic          w_b_fire;

  assign axi_bready  = !rst;
  assign w_b_fire    = axi_bvalid & axi_bready;
  assign outstanding = r_outstanding;
  assign slverr      = r_slverr;
  // A pending AW is already committed to become outstanding, so count it here;
  // otherwise back-to-back accepts could overshoot MAX_OUT by one.
  assign w_out_room  = (({1'b0, r_outstanding} + (OW+1)'(r_awvalid)) < (OW+1)'(MAX_OUT));

  always_ff @(posedge clock) begin
    if (rst) begin
      r_outstanding <= '0;
      r_slverr      <= 1'b0;
    end else begin
      if (w_aw_fire && !w_b_fire) begin
        r_outstanding <= r_outstanding + OW'(1);
      end else if (!w_aw_fire && w_b_fire && r_outstanding != '0) begin
        r_outstanding <= r_outstanding - OW'(1);
      end
      if (w_b_fire && axi_bresp[1]) r_slverr <= 1'b1;
    end
  end
`else
  assign w_out_room = 1'b1;
`endif

endmodule

// File: tb/tb_axi4_wr_aux_pipelined.sv
// Self-checking bench for axi4_wr_aux_pipelined: scoreboard of expected AW beats and
// per-beat wlast, plus cycle-exact scenario checks. Covers AXI4_WR_RESP_TRACK_EN when defined.
module tb_axi4_wr_aux_pipelined;

  localparam int unsigned IDSIZE  = 4;
  localparam int unsigned ASIZE   = 32;
  localparam int unsigned LSIZE   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned CMDW    = IDSIZE + ASIZE + LSIZE;
  localparam int unsigned OW      = $clog2(MAX_OUT + 1);

  logic              clock;
  logic              rst;
  logic [CMDW-1:0]   cmd_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [IDSIZE-1:0] axi_awid;
  logic [ASIZE-1:0]  axi_awaddr;
  logic [LSIZE-1:0]  axi_awlen;
  logic              axi_awvalid;
  logic              axi_awready;
  logic              in_wvalid;
  logic              in_wready;
  logic              axi_wvalid;
  logic              axi_wready;
  logic              axi_wlast;
  logic              stream_en;
  logic              dbg_w_state;
  logic              axi_bvalid;
  logic [1:0]        axi_bresp;
  logic              axi_bready;
  logic              slverr;
  logic [OW-1:0]     outstanding;

  int n_cmp;
  int n_err;
  int b_pending;
  bit b_auto;

  logic [CMDW-1:0] aw_exp_q[$];
  logic [0:0]      w_exp_q[$];

  axi4_wr_aux_pipelined #(
    .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .rst(rst),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .in_wvalid(in_wvalid), .in_wready(in_wready),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .stream_en(stream_en),
`ifdef AXI4_WR_RESP_TRACK_EN
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .slverr(slverr), .outstanding(outstanding),
`endif
    .dbg_w_state(dbg_w_state)
  );

`ifndef AXI4_WR_RESP_TRACK_EN
  assign axi_bready  = 1'b0;
  assign slverr      = 1'b0;
  assign outstanding = '0;
`endif

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CMDW-1:0] mk_cmd(input int id, input logic [31:0] addr, input int len);
    logic [IDSIZE-1:0] i;
    logic [ASIZE-1:0]  a;
    logic [LSIZE-1:0]  l;
    i = IDSIZE'(id);
    a = ASIZE'(addr);
    l = LSIZE'(len);
    return {i, a, l};
  endfunction

  task automatic idle_inputs();
    cmd_tvalid  = 1'b0;
    cmd_tdata   = '0;
    axi_awready = 1'b0;
    in_wvalid   = 1'b0;
    axi_wready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    aw_exp_q.delete();
    w_exp_q.delete();
    b_pending = 0;
    rst = 1'b0;
  endtask

  task automatic send_cmd(input logic [CMDW-1:0] data);
    bit ok;
    ok = 1'b0;
    cmd_tdata  = data;
    cmd_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cmd_tready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    cmd_tvalid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_cmd: accepted=%0d required=1 within 100 cycles", ok);
    end
  endtask

  // Scoreboard monitor: samples at negedge, inputs change only just after posedge
  task automatic monitor();
    logic [CMDW-1:0] exp_aw;
    logic [0:0]      exp_last;
    int              len;
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (axi_awvalid && axi_awready) begin
          n_cmp++;
          b_pending++;
          if (aw_exp_q.size() == 0) begin
            n_err++;
            $display("FAIL aw_unexpected: got AW %h, required none", {axi_awid, axi_awaddr, axi_awlen});
          end else begin
            exp_aw = aw_exp_q.pop_front();
            if ({axi_awid, axi_awaddr, axi_awlen} !== exp_aw) begin
              n_err++;
              $display("FAIL aw_payload: got %h required %h", {axi_awid, axi_awaddr, axi_awlen}, exp_aw);
            end
          end
        end
        if (axi_wvalid && axi_wready) begin
          n_cmp++;
          if (w_exp_q.size() == 0) begin
            n_err++;
            $display("FAIL w_unexpected: got beat wlast=%0b, required no beat", axi_wlast);
          end else begin
            exp_last = w_exp_q.pop_front();
            if (axi_wlast !== exp_last) begin
              n_err++;
              $display("FAIL w_wlast: got %0b required %0b", axi_wlast, exp_last);
            end
          end
        end
        n_cmp++;
        if (axi_wvalid !== (stream_en & in_wvalid) || in_wready !== (stream_en & axi_wready)) begin
          n_err++;
          $display("FAIL w_gate: got wvalid=%0b in_wready=%0b required %0b %0b (stream_en=%0b)",
                   axi_wvalid, in_wready, stream_en & in_wvalid, stream_en & axi_wready, stream_en);
        end
`ifdef AXI4_WR_RESP_TRACK_EN
        if (axi_bvalid && axi_bready && b_pending > 0) b_pending--;
`endif
        if (cmd_tvalid && cmd_tready) begin
          aw_exp_q.push_back(cmd_tdata);
          len = int'(cmd_tdata[LSIZE-1:0]);
          for (int b = 0; b <= len; b++) w_exp_q.push_back(1'(b == len));
        end
      end
    end
  endtask

  task automatic b_responder();
    forever begin
      tick();
      if (b_auto) begin
        axi_bvalid = (b_pending > 0);
        axi_bresp  = 2'b00;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    in_wvalid  = 1'b1;
    axi_wready = 1'b1;
    cmd_tvalid = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clock);
    n_cmp++;
    if (cmd_tready !== 1'b0 || axi_awvalid !== 1'b0 || stream_en !== 1'b0 || axi_wlast !== 1'b0 ||
        axi_wvalid !== 1'b0 || in_wready !== 1'b0 || dbg_w_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got tready=%0b awvalid=%0b stream_en=%0b wlast=%0b wvalid=%0b in_wready=%0b st=%0b required all 0",
               cmd_tready, axi_awvalid, stream_en, axi_wlast, axi_wvalid, in_wready, dbg_w_state);
    end
    n_cmp++;
    if ({axi_awid, axi_awaddr, axi_awlen} !== '0) begin
      n_err++;
      $display("FAIL reset_aw: got %h required 0", {axi_awid, axi_awaddr, axi_awlen});
    end
`ifdef AXI4_WR_RESP_TRACK_EN
    n_cmp++;
    if (axi_bready !== 1'b0 || slverr !== 1'b0 || outstanding !== '0) begin
      n_err++;
      $display("FAIL reset_b: got bready=%0b slverr=%0b outstanding=%0d required 0 0 0", axi_bready, slverr, outstanding);
    end
`endif
    do_reset();
  endtask

  // Three commands len 3,0,7 back to back; caller leaves us just after a posedge with DUT idle
  task automatic test_back_to_back(input int base);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      axi_awready = 1'b1;
      axi_wready  = 1'b1;
      in_wvalid   = 1'b1;
      cmd_tvalid  = (k < 3);
      case (k)
        0:       cmd_tdata = mk_cmd(base,     32'h0000_1000, 3);
        1:       cmd_tdata = mk_cmd(base + 1, 32'h0000_2000, 0);
        2:       cmd_tdata = mk_cmd(base + 2, 32'h0000_3000, 7);
        default: cmd_tdata = '0;
      endcase
      @(negedge clock);
      if (k < 3) begin
        n_cmp++;
        if (cmd_tready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_tready cyc%0d: got %0b required 1", k, cmd_tready);
        end
      end
      n_cmp++;
      if (axi_awvalid !== 1'(k >= 1 && k <= 3)) begin
        n_err++;
        $display("FAIL b2b_awvalid cyc%0d: got %0b required %0b", k, axi_awvalid, k >= 1 && k <= 3);
      end
      n_cmp++;
      if (stream_en !== 1'(k >= 1 && k <= 13)) begin
        n_err++;
        $display("FAIL b2b_stream_en cyc%0d: got %0b required %0b", k, stream_en, k >= 1 && k <= 13);
      end
      n_cmp++;
      if (axi_wlast !== 1'(k == 4 || k == 5 || k == 13)) begin
        n_err++;
        $display("FAIL b2b_wlast cyc%0d: got %0b required %0b", k, axi_wlast, k == 4 || k == 5 || k == 13);
      end
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (aw_exp_q.size() != 0 || w_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d AW / %0d W pending, required 0 / 0", aw_exp_q.size(), w_exp_q.size());
    end
  endtask

  task automatic test_aw_stall();
    int fires;
    fires = 0;
    tick();
    axi_awready = 1'b0;
    axi_wready  = 1'b1;
    in_wvalid   = 1'b1;
    cmd_tvalid  = 1'b1;
    cmd_tdata   = mk_cmd(5, 32'hCAFE_0000, 2);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      @(negedge clock);
      if (cmd_tvalid && cmd_tready) fires++;
    end
    n_cmp++;
    if (fires != 1) begin
      n_err++;
      $display("FAIL stall_accepts: got %0d required 1", fires);
    end
    n_cmp++;
    if (stream_en !== 1'b0 || w_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_w_done: got stream_en=%0b pending=%0d required 0 0", stream_en, w_exp_q.size());
    end
    tick();
    cmd_tvalid  = 1'b0;
    axi_awready = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (axi_awvalid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_aw_fire: got awvalid=%0b required 1", axi_awvalid);
    end
    tick();
    @(negedge clock);
    n_cmp++;
    if (axi_awvalid !== 1'b0 || aw_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_aw_clear: got awvalid=%0b pending=%0d required 0 0", axi_awvalid, aw_exp_q.size());
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_queue_full();
    int fires;
    bit done;
    fires = 0;
    axi_awready = 1'b1;
    axi_wready  = 1'b0;
    in_wvalid   = 1'b1;
    cmd_tvalid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      cmd_tdata = mk_cmd(k, 32'h4000_0000 + 32'(k * 16), 1);
      @(negedge clock);
      if (cmd_tvalid && cmd_tready) fires++;
    end
    n_cmp++;
    if (fires != DEPTH + 1 || cmd_tready !== 1'b0) begin
      n_err++;
      $display("FAIL qfull_accepts: got %0d tready=%0b required %0d 0", fires, cmd_tready, DEPTH + 1);
    end
    fires = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      axi_wready = (k < 2);
      cmd_tdata  = mk_cmd(9, 32'h5000_0000 + 32'(k), 1);
      @(negedge clock);
      if (cmd_tvalid && cmd_tready) fires++;
    end
    n_cmp++;
    if (fires != 1 || cmd_tready !== 1'b0) begin
      n_err++;
      $display("FAIL qfull_reopen: got %0d tready=%0b required 1 0", fires, cmd_tready);
    end
    tick();
    cmd_tvalid = 1'b0;
    axi_wready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (!stream_en && w_exp_q.size() == 0 && aw_exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL qfull_drain: got %0d W pending required 0 within 200 cycles", w_exp_q.size());
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_long_burst();
    int beats;
    int lasts;
    int last_at;
    bit done;
    beats = 0;
    lasts = 0;
    last_at = -1;
    done = 1'b0;
    axi_awready = 1'b1;
    axi_wready  = 1'b0;
    in_wvalid   = 1'b0;
    send_cmd(mk_cmd(3, 32'h8000_0000, 255));
    for (int k = 0; k < 4000; k++) begin
      axi_wready = 1'($urandom_range(0, 1));
      in_wvalid  = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (axi_wvalid && axi_wready) begin
        beats++;
        if (axi_wlast) begin
          lasts++;
          last_at = beats;
        end
      end
      if (beats > 0 && !stream_en) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!done || beats != 256) begin
      n_err++;
      $display("FAIL long_beats: got %0d beats (finished=%0b) required 256", beats, done);
    end
    n_cmp++;
    if (lasts != 1 || last_at != 256) begin
      n_err++;
      $display("FAIL long_wlast: got %0d wlast at beat %0d required 1 at 256", lasts, last_at);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    beats = 0;
    axi_awready = 1'b1;
    axi_wready  = 1'b0;
    in_wvalid   = 1'b1;
    send_cmd(mk_cmd(7, 32'hABCD_0000, 7));
    axi_wready = 1'b1;
    for (int k = 0; k < 50 && beats < 2; k++) begin
      @(negedge clock);
      if (axi_wvalid && axi_wready) beats++;
      if (beats < 2) tick();
    end
    tick();
    rst = 1'b1;
    aw_exp_q.delete();
    w_exp_q.delete();
    b_pending = 0;
    @(negedge clock);
    n_cmp++;
    if (cmd_tready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_tready: got %0b required 0", cmd_tready);
    end
    tick();
    rst = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (axi_awvalid !== 1'b0 || {axi_awid, axi_awaddr, axi_awlen} !== '0 || stream_en !== 1'b0 ||
        axi_wlast !== 1'b0 || axi_wvalid !== 1'b0 || in_wready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_outputs: got awvalid=%0b aw=%h stream_en=%0b wlast=%0b wvalid=%0b in_wready=%0b required all 0",
               axi_awvalid, {axi_awid, axi_awaddr, axi_awlen}, stream_en, axi_wlast, axi_wvalid, in_wready);
    end
    tick();
    test_back_to_back(10);
  endtask

`ifdef AXI4_WR_RESP_TRACK_EN
  task automatic test_resp_track();
    int fires;
    bit done;
    fires = 0;
    b_auto = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    in_wvalid   = 1'b1;
    cmd_tvalid  = 1'b1;
    cmd_tdata   = mk_cmd(1, 32'h9000_0000, 0);
    for (int k = 0; k < 2 * MAX_OUT + 4; k++) begin
      if (k > 0) tick();
      @(negedge clock);
      if (cmd_tvalid && cmd_tready) fires++;
    end
    n_cmp++;
    if (fires != MAX_OUT || cmd_tready !== 1'b0 || outstanding !== OW'(MAX_OUT)) begin
      n_err++;
      $display("FAIL resp_limit: got %0d accepts tready=%0b outstanding=%0d required %0d 0 %0d",
               fires, cmd_tready, outstanding, MAX_OUT, MAX_OUT);
    end
    tick();
    axi_bvalid = 1'b1;
    axi_bresp  = 2'b10;
    @(negedge clock);
    tick();
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
    fires = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clock);
      if (cmd_tvalid && cmd_tready) fires++;
    end
    n_cmp++;
    if (fires != 1 || slverr !== 1'b1) begin
      n_err++;
      $display("FAIL resp_release: got %0d accepts slverr=%0b required 1 1", fires, slverr);
    end
    tick();
    cmd_tvalid = 1'b0;
    b_auto = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (outstanding == '0 && aw_exp_q.size() == 0 && !axi_awvalid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!done || slverr !== 1'b1) begin
      n_err++;
      $display("FAIL resp_drain: got outstanding=%0d slverr=%0b required 0 1", outstanding, slverr);
    end
    tick();
    do_reset();
    @(negedge clock);
    n_cmp++;
    if (slverr !== 1'b0 || axi_bready !== 1'b1) begin
      n_err++;
      $display("FAIL resp_reset: got slverr=%0b bready=%0b required 0 1", slverr, axi_bready);
    end
    tick();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    b_pending = 0;
    b_auto = 1'b1;
    rst = 1'b1;
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
    idle_inputs();
    fork
      monitor();
`ifdef AXI4_WR_RESP_TRACK_EN
      b_responder();
`endif
    join_none
    test_reset();
    test_back_to_back(0);
    test_aw_stall();
    test_queue_full();
    test_long_burst();
    test_reset_mid_burst();
`ifdef AXI4_WR_RESP_TRACK_EN
    test_resp_track();
`endif
    repeat (4) tick();
    n_cmp++;
    if (aw_exp_q.size() != 0 || w_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: got %0d AW / %0d W pending, required 0 / 0", aw_exp_q.size(), w_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
